ro_trng_array: RTL

Parametrised ring-oscillator entropy source. It holds NUM_RO gated ring oscillators of STAGES inverter stages each, built from cinv cells. The ring outputs are XOR-combined, synchronised and decimated, then packed into WORD_W-bit words. Words leave through a valid/ready handshake. The block is the successor to the single 5-stage ring and feeds the TRNG post-processing/readout logic.

---
 rtl/ro_trng_array.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/ro_trng_array.sv
// Ring-oscillator entropy source: NUM_RO gated cinv rings, XOR-combined, synchronised, decimated and packed into words.
// Optional repetition-count health test is compiled in when RO_TRNG_HEALTH_EN is defined.

module cinv (
    input  logic a,
    output logic y
);
    assign y = ~a;
endmodule

module ro_trng_array #(
    parameter int unsigned NUM_RO        = 4,
    parameter int unsigned STAGES        = 5,
    parameter int unsigned WARMUP_CYCLES = 64,
    parameter int unsigned SAMPLE_DIV    = 8,
    parameter int unsigned WORD_W        = 8,
    parameter int unsigned REP_LIMIT     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              test_mode,
    input  logic              test_bit,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              busy,
    output logic [NUM_RO-1:0] ro_mon,
    output logic              health_fail
);

    localparam int unsigned WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam int unsigned DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned CNT_W  = $clog2(WORD_W);

    localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(WARMUP_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        SAMPLE,
        HOLD
    } state_t;

    state_t              state_q, state_d;
    logic                ring_en_q;
    logic [NUM_RO-1:0]   ring_out;
    logic                raw_bit;
    logic                sync1_q, sync2_q;
    logic                sync_bit;
    logic [WARM_W-1:0]   warm_cnt_q;
    logic [DIV_W-1:0]    div_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [WORD_W-1:0]   shift_q;
    logic [WORD_W-1:0]   shift_next;
    logic [WORD_W-1:0]   word_q;
    logic                valid_q;
    logic                load_ok;

    logic tick, word_done, word_load, hold_load, clear_frame;

    // Each ring: a gated first stage (ring_en AND feedback into a cinv) followed by STAGES-1 plain cinv stages.
    for (genvar r = 0; r < NUM_RO; r++) begin : g_ring
        logic [STAGES-1:0] node;
        logic              gate_in;

        assign gate_in = ring_en_q & node[STAGES-1];

        (* keep = "true", dont_touch = "true" *)
        cinv u_stage0 (.a(gate_in), .y(node[0]));

        for (genvar s = 1; s < STAGES; s++) begin : g_stage
            (* keep = "true", dont_touch = "true" *)
            cinv u_inv (.a(node[s-1]), .y(node[s]));
        end

        assign ring_out[r] = node[STAGES-1];
    end

    assign ro_mon   = ring_out & {NUM_RO{ring_en_q}};
    assign raw_bit  = test_mode ? test_bit : (^ring_out);
    assign sync_bit = sync2_q;

    assign shift_next = {shift_q[WORD_W-2:0], sync_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first; a path that skipped one would infer a latch.
        state_d     = state_q;
        tick        = 1'b0;
        word_done   = 1'b0;
        word_load   = 1'b0;
        hold_load   = 1'b0;
        clear_frame = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) state_d = WARMUP;
            end
            WARMUP: begin
                if (!enable) begin
                    state_d     = IDLE;
                    clear_frame = 1'b1;
                end else if (warm_cnt_q == '0) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (!enable) begin
                    state_d     = IDLE;
                    clear_frame = 1'b1;
                end else begin
                    tick      = (div_q == DIV_LAST);
                    word_done = tick && (bit_cnt_q == CNT_LAST);
                    if (word_done) begin
                        if (!valid_q || word_ready) word_load = load_ok;
                        else                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!enable) begin
                    state_d     = IDLE;
                    clear_frame = 1'b1;
                end else if (word_ready) begin
                    state_d   = SAMPLE;
                    hold_load = load_ok;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ring_en_q  <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            warm_cnt_q <= '0;
            div_q      <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            word_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            ring_en_q <= (state_d != IDLE) && !test_mode;
            sync1_q   <= raw_bit;
            sync2_q   <= sync1_q;

            if (state_q == IDLE)                           warm_cnt_q <= WARM_INIT;
            else if (state_q == WARMUP && warm_cnt_q != '0) warm_cnt_q <= warm_cnt_q - WARM_W'(1);

            // Divider is cleared through warm-up, runs in SAMPLE and is left untouched in HOLD.
            if (state_q == WARMUP)      div_q <= '0;
            else if (state_q == SAMPLE) div_q <= tick ? '0 : div_q + DIV_W'(1);

            if (clear_frame) begin
                shift_q   <= '0;
                bit_cnt_q <= '0;
            end else if (tick) begin
                shift_q   <= shift_next;
                bit_cnt_q <= word_done ? '0 : bit_cnt_q + CNT_W'(1);
            end

            if (word_load) begin
                word_q  <= shift_next;
                valid_q <= 1'b1;
            end else if (hold_load) begin
                word_q  <= shift_q;
                valid_q <= 1'b1;
            end else if (valid_q && word_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef RO_TRNG_HEALTH_EN
    localparam int unsigned REP_W = $clog2(REP_LIMIT + 1);

    logic [REP_W-1:0] rep_q, rep_next;
    logic             prev_q;
    logic             fail_q;

    always_comb begin
        rep_next = rep_q;
        if (sync_bit != prev_q)               rep_next = REP_W'(1);
        else if (rep_q != REP_W'(REP_LIMIT))  rep_next = rep_q + REP_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q  <= '0;
            prev_q <= 1'b0;
            fail_q <= 1'b0;
        end else if (state_q == IDLE) begin
            rep_q  <= '0;
            prev_q <= 1'b0;
        end else if (tick) begin
            rep_q  <= rep_next;
            prev_q <= sync_bit;
            if (rep_next == REP_W'(REP_LIMIT)) fail_q <= 1'b1;
        end
    end

    // The flag is registered, so the word completed on the failing tick still goes out.
    assign load_ok     = ~fail_q;
    assign health_fail = fail_q;
`else
    assign load_ok     = 1'b1;
    assign health_fail = 1'b0;
`endif

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign busy       = (state_q != IDLE);

endmodule
